ram_fifo_ctrl: RTL

- Synchronous FIFO controller sitting directly upstream of the dual-port RAM block; the RAM is instantiated alongside, not inside.
- Converts a valid/ready push stream into RAM write commands and RAM read commands into a first-word-fall-through (FWFT) valid/ready pop stream.
- Owns the write/read pointers, occupancy count and a 2-entry read-return buffer that absorbs the RAM's 1-cycle registered read latency.

---
 rtl/ram_fifo_ctrl_if.sv | 38 +++
 rtl/ram_fifo_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream and RAM command bundle for ram_fifo_ctrl.
// slave = FIFO controller side; master = producer, consumer and RAM side.
interface ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  i_push_valid;
    logic [DATA_WIDTH-1:0] i_push_data;
    logic                  o_push_ready;

    logic                  o_pop_valid;
    logic [DATA_WIDTH-1:0] o_pop_data;
    logic                  i_pop_ready;

    logic                  o_ram_valid;
    logic                  o_ram_cs;
    logic                  o_ram_wr_en;
    logic                  o_ram_rd_en;
    logic [ADDR_WIDTH-1:0] o_ram_wraddr;
    logic [ADDR_WIDTH-1:0] o_ram_raddr;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic [DATA_WIDTH-1:0] i_ram_rdata;
    logic                  i_ram_ready;

    modport slave (
        input  i_push_valid, i_push_data, i_pop_ready, i_ram_rdata, i_ram_ready,
        output o_push_ready, o_pop_valid, o_pop_data,
        output o_ram_valid, o_ram_cs, o_ram_wr_en, o_ram_rd_en,
        output o_ram_wraddr, o_ram_raddr, o_ram_wdata
    );

    modport master (
        output i_push_valid, i_push_data, i_pop_ready, i_ram_rdata, i_ram_ready,
        input  o_push_ready, o_pop_valid, o_pop_data,
        input  o_ram_valid, o_ram_cs, o_ram_wr_en, o_ram_rd_en,
        input  o_ram_wraddr, o_ram_raddr, o_ram_wdata
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller in front of an external 1-cycle-latency dual-port RAM.
// Optional registered almost-full watermark: define RAM_FIFO_WATERMARK_EN.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    ram_fifo_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_err
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   r_wrPtr;
    logic [ADDR_WIDTH:0]   r_rdPtr;
    logic [ADDR_WIDTH:0]   r_memCnt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [1:0]            r_bufOcc;
    logic                  r_rdInflight;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_pushFire;
    logic                  w_popFire;
    logic                  w_rdIssue;
    logic [1:0]            w_slotsUsed;
    logic [1:0]            w_occAfterPop;
    logic [ADDR_WIDTH:0]   w_countNext;

    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH);
    assign o_empty = (r_count == '0);
    assign o_err   = r_err;

    assign bus.o_push_ready = !o_full && !i_flush;
    assign bus.o_pop_valid  = (r_bufOcc != 2'd0);
    assign bus.o_pop_data   = r_buf0;

    assign w_pushFire    = i_rst && bus.i_push_valid && bus.o_push_ready;
    assign w_popFire     = i_rst && !i_flush && bus.o_pop_valid && bus.i_pop_ready;
    assign w_occAfterPop = r_bufOcc - {1'b0, w_popFire};
    // A read may only issue if its return will still fit in the 2-entry buffer.
    assign w_slotsUsed   = w_occAfterPop + {1'b0, r_rdInflight};
    assign w_rdIssue     = i_rst && !i_flush && (r_memCnt != '0) && (w_slotsUsed < 2'd2);

    assign bus.o_ram_wr_en  = w_pushFire;
    assign bus.o_ram_rd_en  = w_rdIssue;
    assign bus.o_ram_valid  = w_pushFire | w_rdIssue;
    assign bus.o_ram_cs     = w_pushFire | w_rdIssue;
    assign bus.o_ram_wraddr = i_rst ? r_wrPtr[ADDR_WIDTH-1:0] : '0;
    assign bus.o_ram_raddr  = i_rst ? r_rdPtr[ADDR_WIDTH-1:0] : '0;
    assign bus.o_ram_wdata  = i_rst ? bus.i_push_data : '0;

    always_comb begin
        w_countNext = r_count;
        if (i_flush)
            w_countNext = '0;
        else if (w_pushFire && !w_popFire)
            w_countNext = r_count + ONE;
        else if (!w_pushFire && w_popFire)
            w_countNext = r_count - ONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_memCnt     <= '0;
            r_count      <= '0;
            r_bufOcc     <= 2'd0;
            r_rdInflight <= 1'b0;
            r_err        <= 1'b0;
            r_buf0       <= '0;
            r_buf1       <= '0;
        end else if (i_flush) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_memCnt     <= '0;
            r_count      <= '0;
            r_bufOcc     <= 2'd0;
            r_rdInflight <= 1'b0;
        end else begin
            if (w_pushFire)
                r_wrPtr <= r_wrPtr + ONE;
            if (w_rdIssue)
                r_rdPtr <= r_rdPtr + ONE;
            case ({w_pushFire, w_rdIssue})
                2'b10:   r_memCnt <= r_memCnt + ONE;
                2'b01:   r_memCnt <= r_memCnt - ONE;
                default: r_memCnt <= r_memCnt;
            endcase
            r_rdInflight <= w_rdIssue;
            r_count      <= w_countNext;
            // Head only shifts when a second word remains; otherwise it keeps the last popped value.
            if (w_popFire && (r_bufOcc == 2'd2))
                r_buf0 <= r_buf1;
            if (r_rdInflight) begin
                if (w_occAfterPop == 2'd0)
                    r_buf0 <= bus.i_ram_rdata;
                else
                    r_buf1 <= bus.i_ram_rdata;
                if (!bus.i_ram_ready)
                    r_err <= 1'b1;
            end
            r_bufOcc <= w_occAfterPop + {1'b0, r_rdInflight};
        end
    end

`ifdef RAM_FIFO_WATERMARK_EN
    logic r_almostFull;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_almostFull <= 1'b0;
        else
            r_almostFull <= (int'(w_countNext) >= AF_THRESH);
    end

    assign o_almost_full = r_almostFull;
`else
    logic w_unusedThresh;

    assign w_unusedThresh = (AF_THRESH != 0);
    assign o_almost_full  = 1'b0;
`endif
endmodule
